// File: rtl/apb_sram_pkg.sv
// rtl/apb_sram_pkg.sv - shared types, encodings and helpers for apb_sram_ctrl
// Purpose : controller state encoding, PWRITE encoding, and the byte-offset
//           helper that turns a data width into the word-address shift.
// Ports   : none (package).
package apb_sram_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ACCESS = 2'd3
  } state_e;

  localparam logic APB_WRITE = 1'b1;
  localparam logic APB_READ  = 1'b0;

  // Number of low address bits that select a byte inside one data word.
  function automatic int calc_off(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/apb_sram_ctrl_if.sv
// rtl/apb_sram_ctrl_if.sv - APB bus bundle between a master and apb_sram_ctrl
// Purpose : groups the APB request/response signals; master and slave modports.
// Ports   : PSEL, PENABLE, PWRITE, PADDR[ADDR_WIDTH], PWDATA[DATA_WIDTH],
//           PSTRB[DATA_WIDTH/8] (only with APB_SRAM_CTRL_PSTRB_EN),
//           PRDATA[DATA_WIDTH], PREADY, PSLVERR.
interface apb_sram_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic [DATA_WIDTH-1:0]   PWDATA;
`ifdef APB_SRAM_CTRL_PSTRB_EN
  logic [DATA_WIDTH/8-1:0] PSTRB;
`endif
  logic [DATA_WIDTH-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;

`ifdef APB_SRAM_CTRL_PSTRB_EN
  modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
                  input  PRDATA, PREADY, PSLVERR);
  modport slave  (input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
                  output PRDATA, PREADY, PSLVERR);
`else
  modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                  input  PRDATA, PREADY, PSLVERR);
  modport slave  (input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                  output PRDATA, PREADY, PSLVERR);
`endif

endinterface

// File: rtl/apb_sram_mem.sv
// rtl/apb_sram_mem.sv - DEPTH x DATA_WIDTH word SRAM with byte write enables
// Purpose : one shared write port (clear pointer wins over the APB path) and a
//           synchronous read port whose output register can be forced to zero.
// Ports   : clk, rst (async, active-high, read register only),
//           clr_we/clr_addr/clr_data  - post-reset clear writer,
//           apb_we/apb_addr/apb_data/apb_be - bus writer,
//           re/rzero/raddr/rdata      - registered read port.
module apb_sram_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_we,
  input  logic [AW-1:0]           clr_addr,
  input  logic [DATA_WIDTH-1:0]   clr_data,
  input  logic                    apb_we,
  input  logic [AW-1:0]           apb_addr,
  input  logic [DATA_WIDTH-1:0]   apb_data,
  input  logic [DATA_WIDTH/8-1:0] apb_be,
  input  logic                    re,
  input  logic                    rzero,
  input  logic [AW-1:0]           raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  we;
  logic [AW-1:0]         waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [NB-1:0]         wbe;

  // The clear walk owns the port; bus writes cannot occur during it anyway,
  // but the priority keeps the clear result well defined.
  always_comb begin
    we    = apb_we;
    waddr = apb_addr;
    wdata = apb_data;
    wbe   = apb_be;
    if (clr_we) begin
      we    = 1'b1;
      waddr = clr_addr;
      wdata = clr_data;
      wbe   = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (wbe[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Read register doubles as PRDATA: it only moves on a completing read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= rzero ? '0 : mem[raddr];
  end

endmodule

// File: rtl/apb_sram_ctrl.sv
// rtl/apb_sram_ctrl.sv - APB slave in front of a word-organised on-chip SRAM
// Purpose : byte-addressed APB target with fixed wait states, post-reset
//           hardware clear to RESET_VAL, and PSLVERR on misaligned or
//           out-of-range accesses. Optional byte strobes: APB_SRAM_CTRL_PSTRB_EN.
// Ports   : PCLK  - APB clock
//           PRESET - asynchronous, active-high reset
//           bus   - apb_sram_ctrl_if.slave (PSEL, PENABLE, PWRITE, PADDR,
//                   PWDATA, [PSTRB], PRDATA, PREADY, PSLVERR)
module apb_sram_ctrl
  import apb_sram_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 64,
  parameter int                    WAIT_CYC   = 0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic            PCLK,
  input  logic            PRESET,
  apb_sram_ctrl_if.slave  bus
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int OFF = calc_off(DATA_WIDTH);
  localparam int AW  = $clog2(DEPTH);

  localparam logic [1:0] S_CLEAR  = ST_CLEAR;
  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_WAIT   = ST_WAIT;
  localparam logic [1:0] S_ACCESS = ST_ACCESS;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic [AW-1:0]         clr_ptr;
  logic                  pready_q;
  logic                  pslverr_q;

  logic [ADDR_WIDTH-1:0] word_idx;
  logic [ADDR_WIDTH-1:0] align_mask;
  logic                  addr_err;
  logic                  set_ready;
  logic                  apb_we;
  logic                  rd_en;
  logic [NB-1:0]         wr_be;
  logic [DATA_WIDTH-1:0] rdata;

  // Full-width word index so that addresses aliasing past DEPTH are caught.
  assign word_idx   = bus.PADDR >> OFF;
  assign align_mask = ADDR_WIDTH'((64'd1 << OFF) - 64'd1);
  assign addr_err   = (|(bus.PADDR & align_mask)) || (word_idx >= ADDR_WIDTH'(DEPTH));

  // The edge that raises PREADY: straight from IDLE with no wait states, or
  // the last WAIT edge while the master still holds PSEL.
  assign set_ready = ((state == S_IDLE) && bus.PSEL && (WAIT_CYC == 0)) ||
                     ((state == S_WAIT) && bus.PSEL && (cnt == 4'd1));

  assign rd_en  = set_ready && (bus.PWRITE == APB_READ);

  // Writes commit on the closing edge of ACCESS; the error flag was latched
  // together with PREADY so it reflects the address of this transfer.
  assign apb_we = (state == S_ACCESS) && bus.PSEL && bus.PENABLE &&
                  (bus.PWRITE == APB_WRITE) && !pslverr_q;

`ifdef APB_SRAM_CTRL_PSTRB_EN
  assign wr_be = bus.PSTRB;
`else
  assign wr_be = '1;
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state     <= S_CLEAR;
      cnt       <= 4'd0;
      clr_ptr   <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          if (clr_ptr == AW'(DEPTH - 1)) state <= S_IDLE;
          else                           clr_ptr <= clr_ptr + 1'b1;
        end
        S_IDLE: begin
          if (bus.PSEL) begin
            cnt   <= WAIT_INIT;
            state <= (WAIT_CYC == 0) ? S_ACCESS : S_WAIT;
          end
        end
        S_WAIT: begin
          // Losing PSEL wins over completion: the transfer is abandoned.
          if (!bus.PSEL) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) state <= S_ACCESS;
          end
        end
        S_ACCESS: state <= S_IDLE;
        default:  state <= S_CLEAR;
      endcase
      pready_q  <= set_ready;
      pslverr_q <= set_ready && addr_err;
    end
  end

  apb_sram_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk      (PCLK),
    .rst      (PRESET),
    .clr_we   (state == S_CLEAR),
    .clr_addr (clr_ptr),
    .clr_data (RESET_VAL),
    .apb_we   (apb_we),
    .apb_addr (word_idx[AW-1:0]),
    .apb_data (bus.PWDATA),
    .apb_be   (wr_be),
    .re       (rd_en),
    .rzero    (addr_err),
    .raddr    (word_idx[AW-1:0]),
    .rdata    (rdata)
  );

  assign bus.PRDATA  = rdata;
  assign bus.PREADY  = pready_q;
  assign bus.PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_sram_ctrl.sv
// tb/tb_apb_sram_ctrl.sv - scoreboard bench for apb_sram_ctrl (WAIT_CYC=2 and 0)
`timescale 1ns/1ps
module tb_apb_sram_ctrl;

  localparam logic [31:0] RV = 32'hA5A5A5A5;

  typedef struct {
    logic        is_rd;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        psel, penable, pwrite, use_b;
  logic [31:0] paddr, pwdata;
  logic [31:0] prdata;
  logic        pready, pslverr;
`ifdef APB_SRAM_CTRL_PSTRB_EN
  logic [3:0]  pstrb;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  exp_t        sb[$];
  logic [31:0] mdl [2][64];

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  apb_sram_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_a ();
  apb_sram_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_b ();

  assign bus_a.PSEL    = psel & ~use_b;
  assign bus_b.PSEL    = psel &  use_b;
  assign bus_a.PENABLE = penable;
  assign bus_b.PENABLE = penable;
  assign bus_a.PWRITE  = pwrite;
  assign bus_b.PWRITE  = pwrite;
  assign bus_a.PADDR   = paddr;
  assign bus_b.PADDR   = paddr;
  assign bus_a.PWDATA  = pwdata;
  assign bus_b.PWDATA  = pwdata;
`ifdef APB_SRAM_CTRL_PSTRB_EN
  assign bus_a.PSTRB   = pstrb;
  assign bus_b.PSTRB   = pstrb;
`endif
  assign prdata  = use_b ? bus_b.PRDATA  : bus_a.PRDATA;
  assign pready  = use_b ? bus_b.PREADY  : bus_a.PREADY;
  assign pslverr = use_b ? bus_b.PSLVERR : bus_a.PSLVERR;

  apb_sram_ctrl #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(64), .WAIT_CYC(2), .RESET_VAL(RV)
  ) dut_a (
    .PCLK(PCLK), .PRESET(PRESET), .bus(bus_a)
  );

  apb_sram_ctrl #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(64), .WAIT_CYC(0), .RESET_VAL(RV)
  ) dut_b (
    .PCLK(PCLK), .PRESET(PRESET), .bus(bus_b)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic mdl_reset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 64; i++) mdl[d][i] = RV;
  endtask

  // exp_wait < 0 means "stalled by the clear walk": at least 64 wait cycles.
  task automatic xfer(input string tag, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wd, input int exp_wait);
    exp_t e, o;
    logic err, got, lo_bad;
    logic [3:0] be;
    int idx, waits;
    idx = int'(addr >> 2);
    err = (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'd64);
`ifdef APB_SRAM_CTRL_PSTRB_EN
    be = pstrb;
`else
    be = 4'hF;
`endif
    e.is_rd = !wr;
    e.err   = err;
    e.rdata = 32'h0;
    if (wr) begin
      if (!err)
        for (int b = 0; b < 4; b++)
          if (be[b]) mdl[use_b][idx][b*8 +: 8] = wd[b*8 +: 8];
    end else begin
      e.rdata = err ? 32'h0 : mdl[use_b][idx];
    end
    sb.push_back(e);

    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    @(posedge PCLK); #1 penable = 1'b1;
    waits = 0; got = 1'b0; lo_bad = 1'b0;
    while (!got && waits <= 300) begin
      @(negedge PCLK);
      if (pready) got = 1'b1;
      else begin
        if (pslverr !== 1'b0) lo_bad = 1'b1;
        waits++;
        @(posedge PCLK); #1;
      end
    end
    chk({tag, "_done"}, got, 1'b1);
    chk({tag, "_slverr_lo"}, lo_bad, 1'b0);
    o = sb.pop_front();
    if (got) begin
      if (exp_wait < 0) chk({tag, "_clr_stall"}, waits >= 64, 1'b1);
      else              chk({tag, "_waits"}, waits, exp_wait);
      chk({tag, "_slverr"}, pslverr, o.err);
      if (o.is_rd) chk({tag, "_rdata"}, prdata, o.rdata);
    end
    @(posedge PCLK); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic seen;
    int c0;
    use_b = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'h0; pwdata = 32'h0;
`ifdef APB_SRAM_CTRL_PSTRB_EN
    pstrb = 4'hF;
`endif
    mdl_reset();
    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_a_pready",  bus_a.PREADY,  1'b0);
    chk("rst_a_pslverr", bus_a.PSLVERR, 1'b0);
    chk("rst_a_prdata",  bus_a.PRDATA,  32'h0);
    chk("rst_b_pready",  bus_b.PREADY,  1'b0);
    PRESET = 1'b0;

    // Read during the clear walk stalls, then returns the clear value.
    xfer("clr_rd3c", 1'b0, 32'h3C, 32'h0, -1);

    // Back-to-back write/read, two wait states each.
    xfer("wr10", 1'b1, 32'h10, 32'hDEADBEEF, 2);
    xfer("rd10", 1'b0, 32'h10, 32'h0, 2);
    repeat (3) @(posedge PCLK);
    #1 chk("prdata_hold", bus_a.PRDATA, 32'hDEADBEEF);

    // Error responses; memory must stay unchanged (no aliasing of 0x100 to 0).
    xfer("rd100", 1'b0, 32'h100, 32'h0, 2);
    xfer("wr100", 1'b1, 32'h100, 32'h55AA55AA, 2);
    xfer("rd11",  1'b0, 32'h11, 32'h0, 2);
    xfer("wr11",  1'b1, 32'h11, 32'h12345678, 2);
    xfer("rd10b", 1'b0, 32'h10, 32'h0, 2);
    xfer("rd00",  1'b0, 32'h00, 32'h0, 2);
    xfer("wr3c",  1'b1, 32'h3C, 32'h0BADF00D, 2);
    xfer("rd3c",  1'b0, 32'h3C, 32'h0, 2);

`ifdef APB_SRAM_CTRL_PSTRB_EN
    pstrb = 4'hF; xfer("strb_wrf", 1'b1, 32'h08, 32'hFFFFFFFF, 2);
    pstrb = 4'h5; xfer("strb_wr5", 1'b1, 32'h08, 32'h11223344, 2);
    pstrb = 4'h0; xfer("strb_wr0", 1'b1, 32'h08, 32'h00000000, 2);
    pstrb = 4'hF; xfer("strb_rd",  1'b0, 32'h08, 32'h0, 2);
    chk("strb_value", bus_a.PRDATA, 32'hFF22FF44);
`endif

    // Abort: PSEL drops on the edge where the count would complete.
    seen = 1'b0;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'hCAFEF00D;
    @(posedge PCLK); #1 penable = 1'b1;
    @(negedge PCLK); if (pready) seen = 1'b1;
    @(posedge PCLK); #1 psel = 1'b0; penable = 1'b0;
    repeat (4) begin
      @(negedge PCLK); if (pready) seen = 1'b1;
    end
    chk("abort_no_ready", seen, 1'b0);
    @(posedge PCLK); #1;
    xfer("abort_rd20", 1'b0, 32'h20, 32'h0, 2);

    // Reset during WAIT of a write.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h30; pwdata = 32'h77777777;
    @(posedge PCLK); #1 penable = 1'b1;
    @(posedge PCLK); #1 PRESET = 1'b1;
    #1;
    chk("midrst_pready",  bus_a.PREADY,  1'b0);
    chk("midrst_pslverr", bus_a.PSLVERR, 1'b0);
    chk("midrst_prdata",  bus_a.PRDATA,  32'h0);
    psel = 1'b0; penable = 1'b0;
    repeat (2) @(posedge PCLK);
    #1 PRESET = 1'b0;
    mdl_reset();
    xfer("midrst_rd30", 1'b0, 32'h30, 32'h0, -1);
    xfer("midrst_rd10", 1'b0, 32'h10, 32'h0, 2);

    // Zero-wait instance: back-to-back write/read in 2+2 cycles.
    use_b = 1'b1;
    c0 = cyc;
    xfer("z_wr04", 1'b1, 32'h04, 32'h13579BDF, 0);
    xfer("z_rd04", 1'b0, 32'h04, 32'h0, 0);
    chk("z_cycles", cyc - c0, 4);
    use_b = 1'b0;

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/apb_sram_ctrl.md
# apb_sram_ctrl

APB slave fronting a word-organised on-chip SRAM with parametrised data width, depth and fixed wait-state count, plus hardware clear after reset. Byte-addressed; reports misaligned and out-of-range accesses through PSLVERR. Sits on the peripheral APB bus as the next-generation RAM target, with registered outputs and a defined state machine.

## Interface
- ADDR_WIDTH, 32, width of PADDR (byte address).
- DATA_WIDTH, 32, width of PWDATA/PRDATA; legal 8/16/32/64.
- DEPTH, 64, number of DATA_WIDTH words; ≥2.
- WAIT_CYC, 0, wait cycles inserted per transfer; 0..15.
- RESET_VAL, 0, value written to every word by the post-reset clear.
- Clocking: one clock `PCLK`; reset `PRESET` is asynchronous and active-high.
- PCLK  in  1  APB clock.
- PRESET  in  1  asynchronous, active-high reset.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  byte-lane write strobes (only with APB_SRAM_CTRL_PSTRB_EN).
- PRDATA  out  DATA_WIDTH  read data.
- PREADY  out  1  transfer completion.
- PSLVERR  out  1  error response, valid only while PREADY=1.

## Operation
- OFF = log2(DATA_WIDTH/8); word index = PADDR >> OFF, all upper bits included.
- Error if PADDR[OFF-1:0] != 0 (misaligned) or word index ≥ DEPTH. Errored writes do not modify memory; errored reads return PRDATA=0.
- States: CLEAR, IDLE, WAIT, ACCESS.
- CLEAR: entered on reset. A clear pointer walks 0..DEPTH-1, writing RESET_VAL one word per cycle; after DEPTH-1 it moves to IDLE. PREADY=0 throughout; any transfer presented during CLEAR stalls.
- IDLE: on an edge where PSEL=1 (either phase), it loads cnt=WAIT_CYC. If WAIT_CYC=0, it goes to ACCESS and sets PREADY=1. Otherwise it goes to WAIT.
- WAIT: cnt decrements each edge. On the edge where cnt==1, it sets PREADY=1 and goes to ACCESS. If PSEL drops, it aborts to IDLE with no write and PREADY=0.
- PRDATA and PSLVERR are computed and registered on the same edge that sets PREADY.
- ACCESS: PREADY=1 for exactly one cycle. At the closing edge, a non-errored write commits. Then PREADY→0, PSLVERR→0, next state IDLE.
- Back-to-back transfers: the setup cycle following ACCESS is sampled in IDLE, so no idle cycle is required.
- PRDATA holds its last value between transfers.

## Timing
- Reset values: PREADY=0, PSLVERR=0, PRDATA=0, state=CLEAR, cnt=0, clear pointer=0. Memory is not reset directly; it is cleared by the CLEAR state.
- Reset mid-transfer: outputs are forced to reset values immediately, no write commits, and CLEAR restarts from word 0.
- Transfer length: setup + (WAIT_CYC+1) access cycles. PREADY rises in access cycle WAIT_CYC+1.
- Write data is visible to a read whose setup cycle is the cycle immediately after the write's ACCESS cycle.
- PSLVERR is 0 whenever PREADY is 0.

## Configuration
- APB_SRAM_CTRL_PSTRB_EN defined: the PSTRB port exists, and writes update only the byte lanes whose PSTRB bit is 1. PSTRB=0 on a write is a legal no-op with PSLVERR=0.
- APB_SRAM_CTRL_PSTRB_EN undefined: there is no PSTRB port, and every write updates the full word.

## Structure
- Package apb_sram_pkg holds:
  - the state enum (CLEAR/IDLE/WAIT/ACCESS);
  - the WRITE/READ encoding constants;
  - the function computing OFF from DATA_WIDTH.
- Sub-module apb_sram_mem:
  - DEPTH×DATA_WIDTH array with per-byte write enable;
  - synchronous read port and one write port;
  - the write port is shared between the clear pointer and the APB path, with the clear pointer having priority.

## Test plan
Bench parameters unless stated: DATA_WIDTH=32, DEPTH=64, WAIT_CYC=2, RESET_VAL=0xA5A5A5A5.
- Release reset, read 0x3C: PREADY=0 for ≥64 cycles during CLEAR, then PRDATA=0xA5A5A5A5, PSLVERR=0.
- Write 0xDEADBEEF to 0x10, then read 0x10: each transfer has 2 wait cycles with PREADY high in the 3rd access cycle; read returns 0xDEADBEEF.
- Read and write to 0x100 (index 64) and to 0x11 (misaligned): PSLVERR=1 with PREADY; read PRDATA=0; memory unchanged.
- With PSTRB_EN, write 0x11223344 with PSTRB=4'b0101 over 0xFFFFFFFF at 0x08: readback is 0xFF22FF44.
- Drop PSEL during WAIT of a write to 0x20: no PREADY, and a later read of 0x20 returns RESET_VAL.
- Assert PRESET during the WAIT of a write, then release: all outputs are 0, CLEAR restarts, and the word reads RESET_VAL. Also run a WAIT_CYC=0 build: zero-wait back-to-back write/read at 0x04 completes in 2+2 cycles.
